// File: rtl/xbee_rx_fifo.sv
// XBee receive path: 8N1 UART receiver with mid-bit start qualification and a FWFT receive FIFO.
// Define RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module xbee_rx_fifo #(
    parameter int BAUD       = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int CLKFREQ    = 100_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RxD,
    input  logic                          read_data,
    input  logic                          clr_err,
    output logic [DATA_WIDTH-1:0]         DataOut,
    output logic                          DataRdy,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          FrameErr,
    output logic                          ParityErr,
    output logic                          Overflow,
    output logic                          RxIdle
);
    localparam int DIV   = CLKFREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
    localparam logic [SMP_W-1:0] SMP_HALF = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state;
    logic                   rxd_p0, rxd_p1, rxd_p2;
    logic                   rxd_s, start_edge, tick;
    logic [DIV_W-1:0]       div_cnt;
    logic [SMP_W-1:0]       smp_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic                   rx_idle, frame_err, vld_p0;
`ifdef RX_PARITY_EN
    logic                   par_bad, parity_err;
`endif

    // Stage p0/p1: metastability synchronizer, p2: previous value for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= RxD;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    assign rxd_s      = rxd_p1;
    assign start_edge = rxd_p2 & ~rxd_p1;
    assign tick       = (state != IDLE) && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            div_cnt <= '0;
        else if (state == IDLE || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (state == DATA && tick && smp_cnt == SMP_LAST)
            rx_shift <= {rxd_s, rx_shift[DATA_WIDTH-1:1]};
    end

    // Receiver FSM; the stop-bit sample returns to IDLE at mid-bit so a following start edge is not missed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            smp_cnt   <= '0;
            bit_cnt   <= '0;
            rx_idle   <= 1'b1;
            frame_err <= 1'b0;
            vld_p0    <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            vld_p0    <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state   <= START;
                        smp_cnt <= '0;
                        rx_idle <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (smp_cnt == SMP_HALF) begin
                            smp_cnt <= '0;
                            bit_cnt <= '0;
                            if (rxd_s) begin
                                state   <= IDLE;
                                rx_idle <= 1'b1;
                            end else begin
                                state <= DATA;
`ifdef RX_PARITY_EN
                                par_bad <= 1'b0;
`endif
                            end
                        end else begin
                            smp_cnt <= smp_cnt + SMP_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (smp_cnt == SMP_LAST) begin
                            smp_cnt <= '0;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_LAST)
`ifdef RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                        end else begin
                            smp_cnt <= smp_cnt + SMP_W'(1);
                        end
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (smp_cnt == SMP_LAST) begin
                            smp_cnt    <= '0;
                            state      <= STOP;
                            par_bad    <= ^{rx_shift, rxd_s};
                            parity_err <= ^{rx_shift, rxd_s};
                        end else begin
                            smp_cnt <= smp_cnt + SMP_W'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (smp_cnt == SMP_LAST) begin
                            smp_cnt <= '0;
                            state   <= IDLE;
                            rx_idle <= 1'b1;
                            if (rxd_s)
`ifdef RX_PARITY_EN
                                vld_p0 <= ~par_bad;
`else
                                vld_p0 <= 1'b1;
`endif
                            else
                                frame_err <= 1'b1;
                        end else begin
                            smp_cnt <= smp_cnt + SMP_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_idle <= 1'b1;
                end
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow, full, empty, pop, wr_en, drop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign pop   = read_data & ~empty;
    assign wr_en = vld_p0 & (~full | pop);
    assign drop  = vld_p0 & full & ~pop;

    // Stage p1: FIFO write of the byte qualified at the stop bit
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
        end
    end

    assign DataOut   = empty ? '0 : mem[rd_ptr];
    assign DataRdy   = ~empty;
    assign Count     = count;
    assign FrameErr  = frame_err;
    assign Overflow  = overflow;
    assign RxIdle    = rx_idle;
`ifdef RX_PARITY_EN
    assign ParityErr = parity_err;
`else
    assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_xbee_rx_fifo.sv
// Randomized bench for xbee_rx_fifo against a queue-based model of the receive FIFO.
// Runs with a fast baud rate (DIV=3, 48 clk per bit) to keep frames short.
module tb_xbee_rx_fifo;
    localparam int CLKFREQ = 100_000_000;
    localparam int BAUD    = 2_000_000;
    localparam int OS      = 16;
    localparam int DEPTH   = 16;
    localparam int DIV     = CLKFREQ / (BAUD * OS);
    localparam int BIT     = DIV * OS;

    logic       clk = 1'b0, reset = 1'b0, RxD = 1'b1, read_data = 1'b0, clr_err = 1'b0;
    logic [7:0] DataOut;
    logic       DataRdy, FrameErr, ParityErr, Overflow, RxIdle;
    logic [4:0] Count;

    int         tests = 0, fails = 0, cyc = 0;
    logic [7:0] q[$];
    logic       ovf_m = 1'b0;

    xbee_rx_fifo #(.BAUD(BAUD), .DATA_WIDTH(8), .CLKFREQ(CLKFREQ), .OVERSAMPLE(OS),
                   .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .RxD(RxD), .read_data(read_data), .clr_err(clr_err),
        .DataOut(DataOut), .DataRdy(DataRdy), .Count(Count), .FrameErr(FrameErr),
        .ParityErr(ParityErr), .Overflow(Overflow), .RxIdle(RxIdle));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send_bit(input logic v);
        RxD = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        RxD = 1'b1;
    endtask

    task automatic model_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else ovf_m = 1'b1;
    endtask

    task automatic pop_one;
        read_data = 1'b1;
        @(negedge clk);
        read_data = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0; RxD = 1'b1; read_data = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        q.delete();
        ovf_m = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({DataOut, DataRdy, Count, FrameErr, ParityErr, Overflow, RxIdle} !== {8'h00, 1'b0, 5'd0, 4'b0001}) begin
            fails++;
            $display("FAIL reset_values: got %h expected %h",
                     {DataOut, DataRdy, Count, FrameErr, ParityErr, Overflow, RxIdle}, {8'h00, 1'b0, 5'd0, 4'b0001});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame;
        int t0, t1;
        bit seen;
        seen = 0; t0 = 0; t1 = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                t0 = cyc;
                for (int i = 0; i < 12 * BIT && !seen; i++) begin
                    @(negedge clk);
                    if (DataRdy) begin seen = 1; t1 = cyc; end
                end
            end
        join
        model_push(8'hA5);
        tests++;
        if (!seen || (t1 - t0) < BIT * 19 / 2 - 4 || (t1 - t0) > BIT * 19 / 2 + 8) begin
            fails++;
            $display("FAIL push_latency: got %0d cycles (seen=%0d) expected about %0d", t1 - t0, seen, BIT * 19 / 2);
        end
        tests++;
        if (DataOut !== 8'hA5 || DataOut !== q[0]) begin
            fails++; $display("FAIL single_data: got %h expected %h", DataOut, q[0]);
        end
        tests++;
        if (Count !== 5'(q.size())) begin
            fails++; $display("FAIL single_count: got %0d expected %0d", Count, q.size());
        end
        pop_one();
        tests++;
        if (DataRdy !== 1'b0 || Count !== 5'd0) begin
            fails++; $display("FAIL single_pop: got rdy=%b count=%0d expected rdy=0 count=0", DataRdy, Count);
        end
    endtask

    task automatic test_glitch;
        bit busy, back, fe;
        int extra;
        busy = 0; back = 0; fe = 0; extra = 0;
        RxD = 1'b0;
        for (int i = 0; i < BIT / 2 + 8 && !back; i++) begin
            if (i == BIT / 4) RxD = 1'b1;
            @(negedge clk);
            if (FrameErr) fe = 1;
            if (!RxIdle) busy = 1;
            if (busy && RxIdle) back = 1;
        end
        RxD = 1'b1;
        tests++;
        if (!busy || !back) begin
            fails++; $display("FAIL glitch_idle: got busy=%0d back=%0d expected busy=1 back=1", busy, back);
        end
        repeat (2 * BIT) begin
            @(negedge clk);
            if (FrameErr) fe = 1;
            if (DataRdy) extra = 1;
        end
        tests++;
        if (fe || extra != 0 || Count !== 5'd0) begin
            fails++; $display("FAIL glitch_nopush: got fe=%0d rdy=%0d count=%0d expected 0 0 0", fe, extra, Count);
        end
    endtask

    task automatic test_frame_err;
        int fe_cyc, pe_cyc;
        fe_cyc = 0; pe_cyc = 0;
        fork
            send_frame(8'h3C, 1'b0);
            begin
                for (int i = 0; i < 11 * BIT; i++) begin
                    @(negedge clk);
                    if (FrameErr) fe_cyc++;
                    if (ParityErr) pe_cyc++;
                end
            end
        join
        tests++;
        if (fe_cyc != 1) begin
            fails++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", fe_cyc);
        end
        tests++;
        if (Count !== 5'd0 || DataRdy !== 1'b0 || pe_cyc != 0) begin
            fails++; $display("FAIL frame_err_discard: got count=%0d rdy=%b pe=%0d expected 0 0 0", Count, DataRdy, pe_cyc);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 1'b1);
            model_push(8'(i));
        end
        tests++;
        if (Count !== 5'(q.size()) || Count !== 5'd16) begin
            fails++; $display("FAIL ovf_count: got %0d expected %0d", Count, q.size());
        end
        tests++;
        if (Overflow !== ovf_m || Overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_flag: got %b expected %b", Overflow, ovf_m);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (DataOut !== q[0]) begin
                fails++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, DataOut, q[0]);
            end
            pop_one();
        end
        pop_one();
        tests++;
        if (Count !== 5'd0 || DataRdy !== 1'b0 || Overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_empty: got count=%0d rdy=%b ovf=%b expected 0 0 1", Count, DataRdy, Overflow);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        ovf_m = 1'b0;
        tests++;
        if (Overflow !== ovf_m) begin
            fails++; $display("FAIL ovf_clear: got %b expected %b", Overflow, ovf_m);
        end
    endtask

    task automatic test_full_pop;
        logic [7:0] b;
        bit ok_busy, ok_back;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            model_push(b);
        end
        tests++;
        if (Count !== 5'd16) begin
            fails++; $display("FAIL full_count: got %0d expected 16", Count);
        end
        ok_busy = 0; ok_back = 0;
        fork
            send_frame(8'h77, 1'b1);
            begin
                for (int i = 0; i < 2 * BIT && !ok_busy; i++) begin
                    @(negedge clk);
                    if (!RxIdle) ok_busy = 1;
                end
                for (int i = 0; i < 12 * BIT && ok_busy && !ok_back; i++) begin
                    @(negedge clk);
                    if (RxIdle) ok_back = 1;
                end
                if (ok_back) begin
                    tests++;
                    if (DataOut !== q[0]) begin
                        fails++; $display("FAIL full_head: got %h expected %h", DataOut, q[0]);
                    end
                    pop_one();
                    q.push_back(8'h77);
                end
            end
        join
        tests++;
        if (!ok_back) begin
            fails++; $display("FAIL full_pop_timeout: got busy=%0d back=%0d expected 1 1", ok_busy, ok_back);
        end
        tests++;
        if (Overflow !== 1'b0 || Count !== 5'd16) begin
            fails++; $display("FAIL full_pop_state: got ovf=%b count=%0d expected ovf=0 count=16", Overflow, Count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tests++;
            if (DataOut !== q[0]) begin
                fails++; $display("FAIL full_drain[%0d]: got %h expected %h", i, DataOut, q[0]);
            end
            if (i == DEPTH - 1) begin
                tests++;
                if (DataOut !== 8'h77) begin
                    fails++; $display("FAIL full_last: got %h expected 77", DataOut);
                end
            end
            pop_one();
        end
    endtask

    task automatic test_reset_midframe;
        do_reset();
        send_frame(8'h11, 1'b1);
        model_push(8'h11);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({DataOut, DataRdy, Count, FrameErr, ParityErr, Overflow, RxIdle} !== {8'h00, 1'b0, 5'd0, 4'b0001}) begin
            fails++;
            $display("FAIL midframe_reset: got %h expected %h",
                     {DataOut, DataRdy, Count, FrameErr, ParityErr, Overflow, RxIdle}, {8'h00, 1'b0, 5'd0, 4'b0001});
        end
        RxD = 1'b1;
        q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'h5A, 1'b1);
        model_push(8'h5A);
        tests++;
        if (DataOut !== 8'h5A || Count !== 5'd1) begin
            fails++; $display("FAIL midframe_next: got %h count=%0d expected 5a count=1", DataOut, Count);
        end
        pop_one();
    endtask

    task automatic test_random;
        logic [7:0] b;
        int nrd;
        do_reset();
        for (int f = 0; f < 14; f++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            model_push(b);
            tests++;
            if (Count !== 5'(q.size())) begin
                fails++; $display("FAIL rand_count[%0d]: got %0d expected %0d", f, Count, q.size());
            end
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) begin
                if (q.size() > 0) begin
                    tests++;
                    if (DataOut !== q[0]) begin
                        fails++; $display("FAIL rand_data[%0d]: got %h expected %h", f, DataOut, q[0]);
                    end
                end
                pop_one();
            end
        end
        while (q.size() > 0) begin
            tests++;
            if (DataOut !== q[0]) begin
                fails++; $display("FAIL rand_drain: got %h expected %h", DataOut, q[0]);
            end
            pop_one();
        end
        tests++;
        if (Count !== 5'd0 || Overflow !== ovf_m) begin
            fails++; $display("FAIL rand_end: got count=%0d ovf=%b expected 0 %b", Count, Overflow, ovf_m);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_full_pop();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xbee_rx_fifo.md
Name: xbee_rx_fifo

Overview:
- Receive-side serial block for the XBee link: 8N1 UART receiver with oversampled start-bit qualification, framing check and a first-word-fall-through receive FIFO.
- Sits between the XBee RxD pin and the application logic.
- Replaces the single-byte, self-timed data-ready path with a buffered, read-acknowledged interface, so back-to-back characters are not lost while software is busy.

Parameters:
BAUD, 9600, serial bit rate
DATA_WIDTH, 8, data bits per character, LSB first
CLKFREQ, 100_000_000, clk frequency in Hz
OVERSAMPLE, 16, sample ticks per bit (even, >=8)
FIFO_DEPTH, 16, receive FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-low reset
RxD  in  1  serial input from XBee, asynchronous to clk, idle high
read_data  in  1  pop FIFO head; honoured only while DataRdy=1
clr_err  in  1  clears the sticky Overflow flag
DataOut  out  DATA_WIDTH  FIFO head byte, valid while DataRdy=1
DataRdy  out  1  FIFO not empty
Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
FrameErr  out  1  one-cycle pulse: stop bit sampled low
ParityErr  out  1  one-cycle pulse: parity mismatch (see Optional Feature)
Overflow  out  1  sticky: a received byte was dropped because the FIFO was full
RxIdle  out  1  receiver FSM in IDLE

Behaviour:
- Reset values: DataOut=0, DataRdy=0, Count=0, FrameErr=0, ParityErr=0, Overflow=0, RxIdle=1. Synchronizer flops reset to 1. FIFO pointers reset to 0.
- Synchronizer: RxD passes through a 2-flop synchronizer; all logic below uses the synchronized value.
- Tick generator: DIV = CLKFREQ/(BAUD*OVERSAMPLE), integer floor. Counter runs 0..DIV-1 and emits a 1-cycle tick on wrap. The counter is held at 0 while in IDLE and starts on start-edge detection.
- FSM states:
  - IDLE: a synchronized 1->0 transition moves to START and clears the sample counter.
  - START: on tick OVERSAMPLE/2-1 (mid start bit), RxD=0 moves to DATA; RxD=1 is treated as a glitch and returns to IDLE with no output.
  - DATA: samples every OVERSAMPLE ticks from mid-bit; shifts LSB first; after DATA_WIDTH bits moves to PARITY if enabled, else STOP.
  - STOP: samples at mid stop bit. RxD=1 pushes the byte; RxD=0 pulses FrameErr and discards the byte. Either way returns to IDLE on the same tick, so the next start edge can be caught inside the stop bit.
- Push latency: DataRdy/Count update on the clk edge after the stop-bit sample.
- FIFO read: first-word fall-through; DataOut shows the head combinationally from storage. read_data with DataRdy=1 pops on that clk edge. read_data while empty is ignored (no pointer move, no underflow).
- Push when full:
  - Simultaneous pop: both happen, Count is unchanged, Overflow is not set.
  - No pop: the byte is dropped, Overflow is set, and the FIFO contents are unchanged.
- Overflow clears only on clr_err or reset. If clr_err and a new overflow occur in the same cycle, Overflow stays set.
- Simultaneous push and pop with FIFO empty: a pop while empty is ignored, so Count=1 after the edge.
- Pointers wrap modulo FIFO_DEPTH. Count uses one extra bit to distinguish full from empty.
- Reset asserted mid-frame: the FSM returns to IDLE immediately, the partial byte is lost, and the FIFO is emptied.

Optional Feature:
RX_PARITY_EN:
- Defined: a PARITY state follows DATA and samples an even-parity bit at mid-bit. A mismatch pulses ParityErr for 1 cycle and discards the byte; the stop bit is still checked. A frame with both errors pulses both flags.
- Undefined: no PARITY state, frame is 8N1, and ParityErr is tied 0.

Test Plan:
All scenarios use CLKFREQ=100M, BAUD=9600, OVERSAMPLE=16, which gives DIV=651 and a bit period of 10416 clk.
1. Frame 0xA5, 8N1. Required: DataRdy rises about 9.5 bit periods after the start edge; DataOut=0xA5, Count=1. One read_data pulse returns DataRdy=0 and Count=0.
2. RxD low for 3000 clk, then high. Required: no push, FrameErr=0, RxIdle=1 again within 5300 clk.
3. Frame 0x3C with stop bit driven 0. Required: FrameErr high for exactly 1 cycle, Count=0.
4. Send 17 frames 0x00..0x10 with no reads. Required: Count=16, Overflow=1. Draining yields 0x00..0x0F; 0x10 is lost. clr_err then sets Overflow=0.
5. FIFO full, read_data asserted in the push cycle of frame 0x77. Required: Overflow=0, Count=16, last entry=0x77.
6. Reset pulsed after data bit 3 of a frame, then frame 0x5A sent. Required: reset values are observed, then DataOut=0x5A, Count=1.
